// File: rtl/pkg_6502_bus.sv
// Shared types and widths for the 6502 memory bus arbiter.
// Owner and state encodings are kept separate so the bus mux stays independent of FSM sequencing.
package pkg_6502_bus;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        OWN_CPU,
        OWN_DMA,
        OWN_DBG
    } bus_owner_e;

    typedef enum logic [1:0] {
        S_CPU,
        S_DMA,
        S_DBG
    } arb_state_e;

endpackage

// File: rtl/bus_arbiter_6502.sv
// Arbitrates the shared 6502 memory bus between the CPU, a DMA engine and the debug port.
// The CPU is stalled via RDY only on read cycles; debug always wins over DMA.
//
// state | meaning
// S_CPU | CPU owns the bus; a pending request is taken on the next CPU read
// S_DMA | DMA owns the bus, counting granted cycles toward MAX_BURST
// S_DBG | debug port owns the bus; no limit, CPU frozen until dbg_req drops
module bus_arbiter_6502
    import pkg_6502_bus::*;
#(
    parameter int MAX_BURST = 16,
    parameter int CPU_GUARD = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_dout,
    input  logic              cpu_rw,
    output logic              cpu_rdy,
    output logic [DATA_W-1:0] cpu_din,
    input  logic              dma_req,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    input  logic              dma_rw,
    output logic              dma_gnt,
    output logic [DATA_W-1:0] dma_rdata,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic              dbg_rw,
    output logic              dbg_gnt,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       stall_cnt
);

    // burst may reach MAX_BURST when debug preempts the limiting DMA cycle
    localparam int BURST_W = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);
    localparam int GUARD_W = (CPU_GUARD < 2) ? 1 : $clog2(CPU_GUARD + 1);
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
    localparam logic [GUARD_W-1:0] GUARD_LOAD = GUARD_W'(CPU_GUARD);

    arb_state_e           state, state_next;
    bus_owner_e           owner;
    logic [BURST_W-1:0]   burst, burst_next;
    logic [GUARD_W-1:0]   guard, guard_next;
    logic                 owner_rw;
    logic                 owner_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_CPU;
            burst     <= '0;
            guard     <= '0;
            cpu_rdy   <= 1'b1;
            stall_cnt <= '0;
        end else begin
            state   <= state_next;
            burst   <= burst_next;
            guard   <= guard_next;
            cpu_rdy <= (state_next == S_CPU);
            if (!cpu_rdy && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end

    always_comb begin
        state_next = state;
        burst_next = burst;
        guard_next = guard;
        owner      = OWN_CPU;
        dma_gnt    = 1'b0;
        dbg_gnt    = 1'b0;

        case (state)
            S_CPU: begin
                owner = OWN_CPU;
                // writes are never stalled, so requests only take the bus on a read
                if (cpu_rw) begin
                    if (dbg_req || (dma_req && guard == '0))
                        state_next = dbg_req ? S_DBG : S_DMA;
                    else if (guard != '0)
                        guard_next = guard - GUARD_W'(1);
                end
            end
            S_DMA: begin
                owner   = OWN_DMA;
                dma_gnt = dma_req;
                if (dma_req) begin
                    burst_next = burst + BURST_W'(1);
                    if (burst == BURST_LAST)
                        guard_next = GUARD_LOAD;
                end
                if (dbg_req)
                    state_next = S_DBG;
                else if (!dma_req || burst == BURST_LAST)
                    state_next = S_CPU;
            end
            S_DBG: begin
                owner   = OWN_DBG;
                dbg_gnt = dbg_req;
                if (!dbg_req)
                    state_next = (dma_req && burst < BURST_LAST) ? S_DMA : S_CPU;
            end
            default: begin
                state_next = S_CPU;
            end
        endcase

        if (state_next == S_CPU && state != S_CPU)
            burst_next = '0;
    end

    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_dout;
        owner_rw  = cpu_rw;
        owner_req = 1'b1;
        case (owner)
            OWN_DMA: begin
                mem_addr  = dma_addr;
                mem_wdata = dma_wdata;
                owner_rw  = dma_rw;
                owner_req = dma_req;
            end
            OWN_DBG: begin
                mem_addr  = dbg_addr;
                mem_wdata = dbg_wdata;
                owner_rw  = dbg_rw;
                owner_req = dbg_req;
            end
            default: begin
                mem_addr  = cpu_addr;
                mem_wdata = cpu_dout;
                owner_rw  = cpu_rw;
                owner_req = 1'b1;
            end
        endcase
    end

    // gated by reset so a write in flight when reset hits never lands
    assign mem_we    = !reset && !owner_rw && owner_req;
    assign cpu_din   = mem_rdata;
    assign dma_rdata = mem_rdata;
    assign dbg_rdata = mem_rdata;

endmodule

// File: tb/tb_bus_arbiter_6502.sv
// Scenario bench for bus_arbiter_6502 with a behavioural memory and a write scoreboard.
module tb_bus_arbiter_6502;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_rw;
    logic        cpu_rdy;
    logic [7:0]  cpu_din;
    logic        dma_req;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic        dma_rw;
    logic        dma_gnt;
    logic [7:0]  dma_rdata;
    logic        dbg_req;
    logic [15:0] dbg_addr;
    logic [7:0]  dbg_wdata;
    logic        dbg_rw;
    logic        dbg_gnt;
    logic [7:0]  dbg_rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;
    logic [15:0] stall_cnt;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t exp_q[$];
    wr_t obs_q[$];
    logic [7:0] mem [0:65535];
    int errors = 0;
    int checks = 0;
    int exp_stall = 0;

    always #5 clk = ~clk;

    bus_arbiter_6502 dut (
        .clk(clk), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_rw(cpu_rw),
        .cpu_rdy(cpu_rdy), .cpu_din(cpu_din),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_rw(dma_rw),
        .dma_gnt(dma_gnt), .dma_rdata(dma_rdata),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_rw(dbg_rw),
        .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .stall_cnt(stall_cnt)
    );

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            obs_q.push_back('{addr: mem_addr, data: mem_wdata});
        end
    end

    function automatic logic [7:0] init_val(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cpu_addr = 16'h1234; cpu_dout = 8'hEE; cpu_rw = 1'b0;
        dma_req = 1'b0; dma_addr = 16'h0; dma_wdata = 8'h0; dma_rw = 1'b1;
        dbg_req = 1'b0; dbg_addr = 16'h0; dbg_wdata = 8'h0; dbg_rw = 1'b1;
        repeat (3) cyc();
        checks++; if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL rst_rdy got=%b exp=1", cpu_rdy); end
        checks++; if ({dma_gnt, dbg_gnt} !== 2'b00) begin errors++; $display("FAIL rst_gnt got=%b exp=00", {dma_gnt, dbg_gnt}); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_we got=%b exp=0", mem_we); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL rst_stall got=%0d exp=0", stall_cnt); end
        checks++; if (mem_addr !== 16'h1234) begin errors++; $display("FAIL rst_addr got=%h exp=1234", mem_addr); end
        reset = 1'b0;
        cpu_rw = 1'b1;
        cyc();
        obs_q.delete();
    endtask

    task automatic test_dma_burst();
        cpu_addr = 16'hC000; cpu_rw = 1'b1;
        dma_req = 1'b1; dma_rw = 1'b0; dma_addr = 16'h0200; dma_wdata = 8'h10;
        checks++; if (cpu_rdy !== 1'b1 || dma_gnt !== 1'b0) begin errors++; $display("FAIL burst_start rdy=%b gnt=%b exp 1/0", cpu_rdy, dma_gnt); end
        cyc();
        for (int i = 0; i < 16; i++) begin
            dma_addr = 16'h0200 + 16'(i); dma_wdata = 8'h10 + 8'(i);
            #1;
            checks++;
            if (cpu_rdy !== 1'b0 || dma_gnt !== 1'b1 || mem_addr !== dma_addr || mem_we !== 1'b1) begin
                errors++;
                $display("FAIL burst_cyc%0d rdy=%b gnt=%b addr=%h we=%b exp 0/1/%h/1", i, cpu_rdy, dma_gnt, mem_addr, mem_we, dma_addr);
            end
            exp_q.push_back('{addr: dma_addr, data: dma_wdata});
            cyc();
        end
        dma_addr = 16'h0210; dma_wdata = 8'h20;
        #1;
        checks++; if (cpu_rdy !== 1'b1 || dma_gnt !== 1'b0) begin errors++; $display("FAIL burst_release rdy=%b gnt=%b exp 1/0", cpu_rdy, dma_gnt); end
        checks++; if (mem_addr !== 16'hC000 || cpu_din !== init_val(16'hC000)) begin errors++; $display("FAIL burst_reread addr=%h din=%h exp C000/%h", mem_addr, cpu_din, init_val(16'hC000)); end
        cyc();
        checks++; if (cpu_rdy !== 1'b1 || dma_gnt !== 1'b0) begin errors++; $display("FAIL guard_read rdy=%b gnt=%b exp 1/0", cpu_rdy, dma_gnt); end
        cyc();
        checks++; if (cpu_rdy !== 1'b0 || dma_gnt !== 1'b1) begin errors++; $display("FAIL guard_regrant rdy=%b gnt=%b exp 0/1", cpu_rdy, dma_gnt); end
        exp_q.push_back('{addr: 16'h0210, data: 8'h20});
        cyc();
        dma_req = 1'b0;
        #1;
        checks++; if (dma_gnt !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL drop_gate gnt=%b we=%b exp 0/0", dma_gnt, mem_we); end
        cyc();
        exp_stall += 18;
        checks++; if (cpu_rdy !== 1'b1 || stall_cnt !== 16'(exp_stall)) begin errors++; $display("FAIL burst_stall rdy=%b cnt=%0d exp 1/%0d", cpu_rdy, stall_cnt, exp_stall); end
        while (exp_q.size() > 0) begin
            wr_t e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL burst_sb missing write exp %h<=%h", e.addr, e.data); end
            else begin
                wr_t o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL burst_sb got %h<=%h exp %h<=%h", o.addr, o.data, e.addr, e.data); end
            end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL burst_sb extra writes got=%0d exp=0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_write_no_stall();
        dma_req = 1'b1; dma_rw = 1'b0; dma_addr = 16'h0300; dma_wdata = 8'h77;
        for (int i = 0; i < 3; i++) begin
            cpu_rw = 1'b0; cpu_addr = 16'h01FF - 16'(i); cpu_dout = 8'hA0 + 8'(i);
            #1;
            checks++;
            if (cpu_rdy !== 1'b1 || dma_gnt !== 1'b0 || mem_we !== 1'b1 || mem_addr !== cpu_addr) begin
                errors++;
                $display("FAIL push%0d rdy=%b gnt=%b we=%b addr=%h exp 1/0/1/%h", i, cpu_rdy, dma_gnt, mem_we, mem_addr, cpu_addr);
            end
            exp_q.push_back('{addr: cpu_addr, data: cpu_dout});
            cyc();
        end
        cpu_rw = 1'b1; cpu_addr = 16'h3000;
        #1;
        checks++; if (cpu_rdy !== 1'b1 || dma_gnt !== 1'b0) begin errors++; $display("FAIL push_read rdy=%b gnt=%b exp 1/0", cpu_rdy, dma_gnt); end
        cyc();
        checks++; if (cpu_rdy !== 1'b0 || dma_gnt !== 1'b1) begin errors++; $display("FAIL push_stall rdy=%b gnt=%b exp 0/1", cpu_rdy, dma_gnt); end
        exp_q.push_back('{addr: 16'h0300, data: 8'h77});
        cyc();
        dma_req = 1'b0;
        cyc();
        exp_stall += 2;
        checks++; if (cpu_rdy !== 1'b1 || stall_cnt !== 16'(exp_stall)) begin errors++; $display("FAIL push_stallcnt rdy=%b cnt=%0d exp 1/%0d", cpu_rdy, stall_cnt, exp_stall); end
        while (exp_q.size() > 0) begin
            wr_t e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL push_sb missing write exp %h<=%h", e.addr, e.data); end
            else begin
                wr_t o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL push_sb got %h<=%h exp %h<=%h", o.addr, o.data, e.addr, e.data); end
            end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL push_sb extra writes got=%0d exp=0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_dbg_and_dma();
        cpu_rw = 1'b1; cpu_addr = 16'h4000;
        dma_req = 1'b1; dma_rw = 1'b1; dma_addr = 16'h0500;
        dbg_req = 1'b1; dbg_rw = 1'b0; dbg_addr = 16'h0010; dbg_wdata = 8'h55;
        #1;
        checks++; if (cpu_rdy !== 1'b1 || {dma_gnt, dbg_gnt} !== 2'b00) begin errors++; $display("FAIL both_start rdy=%b gnt=%b exp 1/00", cpu_rdy, {dma_gnt, dbg_gnt}); end
        cyc();
        checks++;
        if (dbg_gnt !== 1'b1 || dma_gnt !== 1'b0 || mem_addr !== 16'h0010 || mem_we !== 1'b1 || cpu_rdy !== 1'b0) begin
            errors++;
            $display("FAIL dbg_first dbg=%b dma=%b addr=%h we=%b rdy=%b exp 1/0/0010/1/0", dbg_gnt, dma_gnt, mem_addr, mem_we, cpu_rdy);
        end
        exp_q.push_back('{addr: 16'h0010, data: 8'h55});
        cyc();
        dbg_req = 1'b0;
        #1;
        checks++; if (dbg_gnt !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL dbg_drop gnt=%b we=%b exp 0/0", dbg_gnt, mem_we); end
        cyc();
        checks++;
        if (dma_gnt !== 1'b1 || mem_addr !== 16'h0500 || mem_we !== 1'b0 || dma_rdata !== init_val(16'h0500)) begin
            errors++;
            $display("FAIL dma_resume gnt=%b addr=%h we=%b rdata=%h exp 1/0500/0/%h", dma_gnt, mem_addr, mem_we, dma_rdata, init_val(16'h0500));
        end
        cyc();
        dma_req = 1'b0;
        cyc();
        cpu_addr = 16'h0010;
        #1;
        exp_stall += 4;
        checks++; if (cpu_rdy !== 1'b1 || stall_cnt !== 16'(exp_stall)) begin errors++; $display("FAIL both_stall rdy=%b cnt=%0d exp 1/%0d", cpu_rdy, stall_cnt, exp_stall); end
        checks++; if (cpu_din !== 8'h55) begin errors++; $display("FAIL dbg_write_readback got=%h exp=55", cpu_din); end
        cyc();
        while (exp_q.size() > 0) begin
            wr_t e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL both_sb missing write exp %h<=%h", e.addr, e.data); end
            else begin
                wr_t o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL both_sb got %h<=%h exp %h<=%h", o.addr, o.data, e.addr, e.data); end
            end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL both_sb extra writes got=%0d exp=0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_dbg_preempt();
        cpu_rw = 1'b1; cpu_addr = 16'h5000;
        dma_req = 1'b1; dma_rw = 1'b0; dma_addr = 16'h0600; dma_wdata = 8'h30;
        dbg_rw = 1'b1; dbg_addr = 16'h0020;
        cyc();
        for (int i = 0; i < 16; i++) begin
            dma_addr = 16'h0600 + 16'(i); dma_wdata = 8'h30 + 8'(i);
            if (i == 4) dbg_req = 1'b1;
            #1;
            checks++;
            if (dma_gnt !== 1'b1 || cpu_rdy !== 1'b0) begin errors++; $display("FAIL pre_dma%0d gnt=%b rdy=%b exp 1/0", i, dma_gnt, cpu_rdy); end
            exp_q.push_back('{addr: dma_addr, data: dma_wdata});
            cyc();
            if (i == 4) begin
                checks++;
                if (dbg_gnt !== 1'b1 || dma_gnt !== 1'b0 || mem_addr !== 16'h0020 || mem_we !== 1'b0 || dbg_rdata !== init_val(16'h0020)) begin
                    errors++;
                    $display("FAIL pre_dbg dbg=%b dma=%b addr=%h we=%b rdata=%h exp 1/0/0020/0/%h", dbg_gnt, dma_gnt, mem_addr, mem_we, dbg_rdata, init_val(16'h0020));
                end
                cyc();
                dbg_req = 1'b0;
                #1;
                checks++; if (dbg_gnt !== 1'b0 || dma_gnt !== 1'b0) begin errors++; $display("FAIL pre_dbgdrop dbg=%b dma=%b exp 0/0", dbg_gnt, dma_gnt); end
                cyc();
            end
        end
        exp_stall += 18;
        checks++; if (cpu_rdy !== 1'b1 || dma_gnt !== 1'b0) begin errors++; $display("FAIL pre_limit rdy=%b gnt=%b exp 1/0", cpu_rdy, dma_gnt); end
        checks++; if (stall_cnt !== 16'(exp_stall)) begin errors++; $display("FAIL pre_stall got=%0d exp=%0d", stall_cnt, exp_stall); end
        dma_req = 1'b0;
        cyc();
        while (exp_q.size() > 0) begin
            wr_t e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL pre_sb missing write exp %h<=%h", e.addr, e.data); end
            else begin
                wr_t o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL pre_sb got %h<=%h exp %h<=%h", o.addr, o.data, e.addr, e.data); end
            end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL pre_sb extra writes got=%0d exp=0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_reset_mid_burst();
        cpu_rw = 1'b1; cpu_addr = 16'h6000;
        dma_req = 1'b1; dma_rw = 1'b0; dma_addr = 16'h0700; dma_wdata = 8'h40;
        cyc();
        checks++; if (dma_gnt !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL rmid_grant gnt=%b we=%b exp 1/1", dma_gnt, mem_we); end
        exp_q.push_back('{addr: 16'h0700, data: 8'h40});
        cyc();
        dma_addr = 16'h0701; dma_wdata = 8'h41;
        reset = 1'b1;
        #1;
        exp_stall = 0;
        checks++; if (mem_we !== 1'b0 || dma_gnt !== 1'b0) begin errors++; $display("FAIL rmid_gate we=%b gnt=%b exp 0/0", mem_we, dma_gnt); end
        checks++; if (cpu_rdy !== 1'b1 || stall_cnt !== 16'd0) begin errors++; $display("FAIL rmid_vals rdy=%b cnt=%0d exp 1/0", cpu_rdy, stall_cnt); end
        cyc();
        reset = 1'b0;
        dma_req = 1'b0;
        #1;
        checks++; if (cpu_rdy !== 1'b1 || mem_addr !== 16'h6000 || dma_gnt !== 1'b0) begin errors++; $display("FAIL rmid_after rdy=%b addr=%h gnt=%b exp 1/6000/0", cpu_rdy, mem_addr, dma_gnt); end
        cyc();
        checks++; if (stall_cnt !== 16'(exp_stall)) begin errors++; $display("FAIL rmid_stall got=%0d exp=%0d", stall_cnt, exp_stall); end
        while (exp_q.size() > 0) begin
            wr_t e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL rmid_sb missing write exp %h<=%h", e.addr, e.data); end
            else begin
                wr_t o = obs_q.pop_front();
                if (o !== e) begin errors++; $display("FAIL rmid_sb got %h<=%h exp %h<=%h", o.addr, o.data, e.addr, e.data); end
            end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL rmid_sb extra writes got=%0d exp=0", obs_q.size()); end
        obs_q.delete();
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = init_val(16'(i));
        test_reset();
        test_dma_burst();
        test_write_no_stall();
        test_dbg_and_dma();
        test_dbg_preempt();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
